// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, RAM geometry and
// state-class helpers used to derive the registered handshake/status outputs.
package prog_loader_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_WRITE   = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } state_e;

  // States in which a byte may be taken from the stream.
  function automatic logic accepts_byte(input state_e s);
    logic r;
    case (s)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: r = 1'b1;
      default:                                  r = 1'b0;
    endcase
    return r;
  endfunction

  // States that make up an active load frame (core held in reset, busy high).
  function automatic logic in_frame(input state_e s);
    logic r;
    case (s)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE: r = 1'b1;
      default:                                           r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles big-endian 16-bit words, writes them
// into fake_ram from BASE_ADDR upward and holds the core in reset meanwhile.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
  parameter int                MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_dataI,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_count
);

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       index_q, index_d;
  logic [7:0]        hi_q, hi_d;
  logic              in_ready_q, in_ready_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [WORD_W-1:0] ram_dataI_q, ram_dataI_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       word_count_q, word_count_d;
  logic              accept;
  logic [15:0]       len_full;

  assign accept   = in_valid & in_ready_q;
  assign len_full = {len_q[15:8], in_data};

  // Next-state logic; status outputs are derived from the next state so they
  // are registered yet line up with the state they describe.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    index_d      = index_q;
    hi_d         = hi_q;
    ram_addr_d   = ram_addr_q;
    ram_dataI_d  = ram_dataI_q;
    word_count_d = word_count_q;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_d      = S_LEN_HI;
          word_count_d = 16'd0;
          index_d      = 16'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = in_data;
          state_d     = S_LEN_LO;
        end else begin
          state_d = S_LEN_HI;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = len_full;
          if (len_full == 16'd0) begin
            state_d = S_DONE;
          end else if ({1'b0, len_full} > MAX_LEN) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA_HI;
          end
        end else begin
          state_d = S_LEN_LO;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          hi_d    = in_data;
          state_d = S_DATA_LO;
        end else begin
          state_d = S_DATA_HI;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          ram_dataI_d = {hi_q, in_data};
          ram_addr_d  = BASE_ADDR + index_q;
          state_d     = S_WRITE;
        end else begin
          state_d = S_DATA_LO;
        end
      end
      S_WRITE: begin
        index_d      = index_q + 16'd1;
        word_count_d = word_count_q + 16'd1;
        if (index_q + 16'd1 == len_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DATA_HI;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d  = accepts_byte(state_d);
    busy_d      = in_frame(state_d);
    cpu_reset_d = in_frame(state_d) | (state_d == S_ERROR);
    ram_we_d    = (state_d == S_WRITE);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERROR);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      len_q        <= 16'd0;
      index_q      <= 16'd0;
      hi_q         <= 8'd0;
      in_ready_q   <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= BASE_ADDR;
      ram_dataI_q  <= 16'd0;
      cpu_reset_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      word_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      index_q      <= index_d;
      hi_q         <= hi_d;
      in_ready_q   <= in_ready_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_dataI_q  <= ram_dataI_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      word_count_q <= word_count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_dataI  = ram_dataI_q;
  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = word_count_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer-side counterpart to the instruction-fetch read path of fake_ram.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words.
- Writes each word into fake_ram through its write port (we, addr, dataI).
- Holds the CPU core in reset while a program image is loading, then releases it so the core fetches from BASE_ADDR onward.

Parameters:
- BASE_ADDR, 16'h0000, RAM word address of the first loaded word.
- MAX_WORDS, 256, largest accepted image length in words; longer headers are rejected.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load frame; honoured only in IDLE.
- in_valid  in  1  byte on in_data is valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- ram_we  out  1  write strobe to fake_ram.
- ram_addr  out  16  write word address to fake_ram.
- ram_dataI  out  16  write data to fake_ram.
- cpu_reset  out  1  reset request to the core (ORed into the core reset at top level).
- busy  out  1  load frame in progress.
- done  out  1  one-cycle pulse when a load completes successfully.
- err  out  1  level; header length exceeded MAX_WORDS.
- word_count  out  16  number of words written in the current or last frame.

Behaviour:
- Byte transfer: a byte is taken at the rising edge where in_valid=1 and in_ready=1. With in_valid=0 the loader waits indefinitely; no timeout.
- Reset values: state=IDLE, in_ready=0, ram_we=0, ram_addr=BASE_ADDR, ram_dataI=0, cpu_reset=0, busy=0, done=0, err=0, word_count=0, internal length N=0, index=0.
- Frame format: LEN_HI, LEN_LO (N, big-endian), then N words, each sent high byte first.
- States and transitions:
  - IDLE: in_ready=0. On start=1, go to LEN_HI, clear word_count, index and err.
  - LEN_HI: in_ready=1. On accept, latch N[15:8], go to LEN_LO.
  - LEN_LO: in_ready=1. On accept, latch N[7:0]. Then:
    - full N == 0: go to DONE.
    - full N > MAX_WORDS: go to ERROR.
    - otherwise: go to DATA_HI.
  - DATA_HI: in_ready=1. On accept, latch the high byte, go to DATA_LO.
  - DATA_LO: in_ready=1. On accept, latch the low byte, go to WRITE.
  - WRITE: in_ready=0, ram_we=1 for exactly this one cycle.
    - ram_addr = BASE_ADDR + index, modulo 2^16 (wraps past 16'hFFFF).
    - ram_dataI = {high byte, low byte}.
    - Leaving WRITE: index and word_count each increment by 1.
    - If index+1 == N, go to DONE; else go to DATA_HI.
  - DONE: done=1 for one cycle, cpu_reset=0, busy=0; then IDLE.
  - ERROR: err=1, cpu_reset=1, in_ready=0. Leaves only on start (to LEN_HI, clearing err) or reset.
- Output rules:
  - cpu_reset=1 and busy=1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE; cpu_reset is also 1 in ERROR.
  - ram_addr and ram_dataI hold their last values outside WRITE.
  - ram_we is only ever 1 in WRITE.
- Latency:
  - Low byte of word k accepted at edge t: ram_we is high during cycle t..t+1, and fake_ram commits at edge t+1.
  - Last word: done is high during cycle t+1..t+2, and cpu_reset falls in that same cycle.
- Throughput: 2 bytes + 1 write cycle = 3 cycles per word at best.
- Boundary cases:
  - start in any state other than IDLE or ERROR is ignored.
  - Simultaneous start and reset: reset wins.
  - Reset mid-frame: immediate return to reset values; words already written stay in RAM; the core is released because cpu_reset returns to 0.
  - N == MAX_WORDS is accepted.
  - in_valid with in_ready=0 (IDLE, WRITE, DONE, ERROR): the byte is not consumed.

Decomposition:
- Shared package / include holds:
  - state encodings (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR; 3-bit);
  - RAM word width (16) and address width (16), shared with fake_ram and pc_unit.
- Single module; no sub-module is natural. The byte-pair assembly is two registers inside the FSM.

Test Plan:
- Normal load: reset 2 cycles, start; bytes 00 03 12 34 AB CD 00 07 -> ram_we pulses 3 times at addr 0000/0001/0002 with data 1234/ABCD/0007; done 1 cycle after the third write; cpu_reset falls with done; word_count=3; fake_ram readback matches.
- Zero length: start; bytes 00 00 -> no ram_we; done one cycle after LEN_LO is accepted; word_count=0.
- Over-length: MAX_WORDS=256; bytes 01 01 -> err=1, cpu_reset held 1, in_ready=0, no writes; then start followed by a valid frame -> err clears and the load completes.
- Backpressure and gaps: in_valid toggled randomly, plus in_valid held high during WRITE -> no byte lost or duplicated; exactly N writes.
- Address wrap: BASE_ADDR=16'hFFFF, frame 00 02 11 11 22 22 -> writes at FFFF then 0000.
- Reset mid-frame: reset asserted after the second data byte of a 4-word frame -> all outputs return to reset values the next cycle; the word already written is still in RAM.
